// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan decoder: active-low segment codes
// (bit order g..a) and the frame-tracking FSM state type.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic {
    SYNC = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the hex-to-7-segment encoder table. Any code outside
// the 16 valid glyphs (blank and dash included) yields nibble 0 with o_bad set.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_bad
);

  always_comb begin
    o_nibble = 4'h0;
    o_bad    = 1'b0;
    case (i_seg)
      SEG_0:     o_nibble = 4'h0;
      SEG_1:     o_nibble = 4'h1;
      SEG_2:     o_nibble = 4'h2;
      SEG_3:     o_nibble = 4'h3;
      SEG_4:     o_nibble = 4'h4;
      SEG_5:     o_nibble = 4'h5;
      SEG_6:     o_nibble = 4'h6;
      SEG_7:     o_nibble = 4'h7;
      SEG_8:     o_nibble = 4'h8;
      SEG_9:     o_nibble = 4'h9;
      SEG_A:     o_nibble = 4'hA;
      SEG_B:     o_nibble = 4'hB;
      SEG_C:     o_nibble = 4'hC;
      SEG_D:     o_nibble = 4'hD;
      SEG_E:     o_nibble = 4'hE;
      SEG_F:     o_nibble = 4'hF;
      SEG_BLANK: o_bad    = 1'b1;
      SEG_DASH:  o_bad    = 1'b1;
      default:   o_bad    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Rebuilds hex frames from a multiplexed active-low segment/anode bus, with a
// per-digit stability filter and scan-order checking. Optional: SEG_DP_CAPTURE_EN.
module seven_seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [7:0]              SegIn,
  input  logic [NUM_DIGITS-1:0]   AnIn,
  output logic [4*NUM_DIGITS-1:0] Value,
  output logic [NUM_DIGITS-1:0]   DigErr,
  output logic                    FrameValid,
  output logic                    SeqErr
`ifdef SEG_DP_CAPTURE_EN
  ,
  output logic [NUM_DIGITS-1:0]   DpOut
`endif
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

`ifdef SEG_DP_CAPTURE_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif

  logic [SEG_W-1:0] w_seg_in;
`ifdef SEG_DP_CAPTURE_EN
  assign w_seg_in = SegIn;
`else
  // The dp bit is dropped before the register so it cannot disturb stability.
  logic w_unused_dp;
  assign w_unused_dp = SegIn[7];
  assign w_seg_in    = SegIn[6:0];
`endif

  logic [SEG_W-1:0]                r_seg;
  logic [NUM_DIGITS-1:0]           r_an;
  logic [CNT_W-1:0]                r_cnt;
  scan_state_t                     r_state;
  logic [IDX_W-1:0]                r_exp;
  logic [NUM_DIGITS-1:0][3:0]      r_buf_nib;
  logic [NUM_DIGITS-1:0]           r_buf_bad;
  logic                            r_done;
  logic [NUM_DIGITS-1:0][3:0]      r_value;
  logic [NUM_DIGITS-1:0]           r_digerr;
  logic                            r_fv;
  logic                            r_seqerr;

  logic [NUM_DIGITS-1:0] w_zeros;
  logic                  w_onehot;
  logic                  w_multi;
  logic                  w_same;
  logic                  w_hit;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      w_prev_exp;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [3:0]            w_nib;
  logic                  w_bad;

  assign w_zeros  = ~r_an;
  assign w_onehot = (w_zeros != '0) && ((w_zeros & (w_zeros - 1'b1)) == '0);
  assign w_multi  = (w_zeros != '0) && !w_onehot;
  assign w_same   = ({w_seg_in, AnIn} == {r_seg, r_an});
  // One edge before the counter saturates is the single latch point per dwell.
  assign w_hit    = w_onehot && w_same && (r_cnt == CNT_W'(STABLE_CYC - 1));
  assign w_prev_exp = (r_exp == '0) ? LAST_IDX : r_exp - 1'b1;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_zeros[i]) w_idx = IDX_W'(i);
    end
  end

  always_comb begin
    w_cnt_next = '0;
    if (w_onehot && w_same) begin
      w_cnt_next = (r_cnt == CNT_W'(STABLE_CYC)) ? r_cnt : r_cnt + 1'b1;
    end
  end

  seg_pattern_decode u_decode (
    .i_seg    (r_seg[6:0]),
    .o_nibble (w_nib),
    .o_bad    (w_bad)
  );

`ifdef SEG_DP_CAPTURE_EN
  logic [NUM_DIGITS-1:0] r_buf_dp;
  logic [NUM_DIGITS-1:0] r_dp_out;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_buf_dp <= '0;
      r_dp_out <= '0;
    end else begin
      if (r_done) r_dp_out <= r_buf_dp;
      if ((r_state == SCAN) && w_multi) begin
        r_buf_dp <= '0;
      end else if (w_hit && (((r_state == SYNC) && (w_idx == '0)) ||
                             ((r_state == SCAN) && (w_idx == r_exp)))) begin
        r_buf_dp[w_idx] <= ~r_seg[7];
      end else if (w_hit && (r_state == SCAN) && (w_idx != w_prev_exp)) begin
        r_buf_dp <= '0;
      end
    end
  end

  assign DpOut = r_dp_out;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_seg     <= '0;
      r_an      <= '0;
      r_cnt     <= '0;
      r_state   <= SYNC;
      r_exp     <= '0;
      r_buf_nib <= '0;
      r_buf_bad <= '0;
      r_done    <= 1'b0;
      r_value   <= '0;
      r_digerr  <= '0;
      r_fv      <= 1'b0;
      r_seqerr  <= 1'b0;
    end else begin
      r_seg    <= w_seg_in;
      r_an     <= AnIn;
      r_cnt    <= w_cnt_next;
      r_done   <= 1'b0;
      r_fv     <= 1'b0;
      r_seqerr <= 1'b0;
      if (r_done) begin
        r_value  <= r_buf_nib;
        r_digerr <= r_buf_bad;
        r_fv     <= 1'b1;
      end
      case (r_state)
        SYNC: begin
          if (w_hit && (w_idx == '0)) begin
            r_buf_nib[0] <= w_nib;
            r_buf_bad[0] <= w_bad;
            r_exp        <= IDX_W'(1);
            r_state      <= SCAN;
          end
        end
        SCAN: begin
          if (w_multi || (w_hit && (w_idx != r_exp) && (w_idx != w_prev_exp))) begin
            r_seqerr  <= 1'b1;
            r_buf_nib <= '0;
            r_buf_bad <= '0;
            r_exp     <= '0;
            r_state   <= SYNC;
          end else if (w_hit && (w_idx == r_exp)) begin
            r_buf_nib[r_exp] <= w_nib;
            r_buf_bad[r_exp] <= w_bad;
            if (r_exp == LAST_IDX) begin
              r_exp  <= '0;
              r_done <= 1'b1;
            end else begin
              r_exp <= r_exp + 1'b1;
            end
          end
        end
        default: r_state <= SYNC;
      endcase
    end
  end

  assign Value      = r_value;
  assign DigErr     = r_digerr;
  assign FrameValid = r_fv;
  assign SeqErr     = r_seqerr;

endmodule
